// File: rtl/pic_ram_reader_pkg.sv
// rtl/pic_ram_reader_pkg.sv - shared sizes, FSM encoding and helpers for the picture RAM reader
package pic_ram_reader_pkg;

   localparam int DEF_NPIX       = 65536;
   localparam int DEF_AW         = 18;
   localparam int DEF_DW         = 24;
   localparam int DEF_RD_LAT     = 1;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Width of an occupancy counter that must also represent the full value.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pic_ram_reader_if.sv
// rtl/pic_ram_reader_if.sv - picture RAM read port plus pixel stream bundle
interface pic_ram_reader_if
   import pic_ram_reader_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) ();

   logic [DW-1:0] RAM_PIC_Q;
   logic          RAM_PIC_OE;
   logic          RAM_PIC_WE;
   logic [AW-1:0] RAM_PIC_A;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready;
   logic          pix_last;

   // Reader side: drives the RAM read port and sources the pixel stream.
   modport master (
      input  RAM_PIC_Q, pix_ready,
      output RAM_PIC_OE, RAM_PIC_WE, RAM_PIC_A, pix_data, pix_valid, pix_last
   );

   // RAM plus stream sink side.
   modport slave (
      output RAM_PIC_Q, pix_ready,
      input  RAM_PIC_OE, RAM_PIC_WE, RAM_PIC_A, pix_data, pix_valid, pix_last
   );

endinterface

// File: rtl/pic_ram_reader_sync_fifo.sv
// rtl/pic_ram_reader_sync_fifo.sv - first-word fall-through FIFO for returning RAM data
module sync_fifo
   import pic_ram_reader_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [DW-1:0]          push_data,
   input  logic                   pop,
   output logic [DW-1:0]          head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign head = mem[rd_ptr];

   // Pointer/occupancy update; push and pop together leave count unchanged even when full.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         assert (!(push && !pop && count == CW'(DEPTH)));
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pic_ram_reader.sv
// rtl/pic_ram_reader.sv - streams a full frame back out of the picture RAM after the controller finishes
module pic_ram_reader
   import pic_ram_reader_pkg::*;
#(
   parameter int NPIX       = DEF_NPIX,
   parameter int AW         = DEF_AW,
   parameter int DW         = DEF_DW,
   parameter int RD_LAT     = DEF_RD_LAT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   pic_ram_reader_if.master bus,
   output logic             busy,
   output logic             frame_done
);

   localparam int            CW        = cnt_w(FIFO_DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

   state_t          state;
   logic            oe;
   logic [AW-1:0]   addr_q;
   logic [AW-1:0]   rd_addr;
   logic [AW-1:0]   beat_cnt;
   logic [RD_LAT-1:0] dly;
   logic [CW-1:0]   fifo_count;
   logic [DW-1:0]   fifo_head;
   logic            push;
   logic            pop;
   logic            credit_ok;
   logic            last_beat;

   // The read in the OE register is not yet in the delay line but already owns a FIFO slot;
   // a pop this cycle frees one.
   assign credit_ok = (int'(fifo_count) + int'(oe) + $countones(dly)) < (FIFO_DEPTH + int'(pop));

   assign push      = dly[RD_LAT-1];
   assign pop       = bus.pix_valid && bus.pix_ready;
   assign last_beat = (beat_cnt == LAST_ADDR);

   assign bus.pix_valid  = (fifo_count != '0);
   assign bus.pix_data   = bus.pix_valid ? fifo_head : '0;
   assign bus.pix_last   = bus.pix_valid && last_beat;
   assign bus.RAM_PIC_OE = oe;
   assign bus.RAM_PIC_A  = addr_q;
   assign bus.RAM_PIC_WE = 1'b0;

   // Frame sequencing, read issue and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         oe         <= 1'b0;
         addr_q     <= '0;
         rd_addr    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         oe         <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_STREAM;
                  busy    <= 1'b1;
                  rd_addr <= '0;
               end
            end
            ST_STREAM: begin
               if (credit_ok) begin
                  oe      <= 1'b1;
                  addr_q  <= rd_addr;
                  rd_addr <= rd_addr + 1'b1;
                  if (rd_addr == LAST_ADDR)
                     state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (pop && last_beat) begin
                  state      <= ST_DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!start)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // OE delayed by the RAM latency marks the cycle its data is on RAM_PIC_Q.
   always_ff @(posedge clk) begin
      if (rst)
         dly <= '0;
      else
         dly <= RD_LAT'({dly, oe});
   end

   // Accepted-beat counter; restarts whenever the reader is idle.
   always_ff @(posedge clk) begin
      if (rst || state == ST_IDLE)
         beat_cnt <= '0;
      else if (pop)
         beat_cnt <= beat_cnt + 1'b1;
   end

   sync_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.RAM_PIC_Q),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_pic_ram_reader.sv
// tb/tb_pic_ram_reader.sv - scoreboard bench for the picture RAM reader
module tb_pic_ram_reader;

   logic clk = 1'b0;
   logic rst;
   logic start0;
   logic start1;
   logic busy0, busy1;
   logic frame_done0, frame_done1;

   int n_cmp = 0;
   int n_err = 0;
   int cycle = 0;

   logic [24:0] exp0[$];
   logic [24:0] exp1[$];
   logic [17:0] addr_log[$];
   int issued0 = 0, acc0 = 0, beats0 = 0, max_out = 0, we_seen0 = 0;
   int beats1 = 0, we_seen1 = 0;
   int last_hs_cycle = -10;
   logic last_hs_last = 1'b0;
   logic stall0 = 1'b0;
   logic [23:0] hold_data;
   logic hold_last;
   logic [23:0] p1, p2;

   pic_ram_reader_if #(.AW(18), .DW(24)) bus0 ();
   pic_ram_reader_if #(.AW(18), .DW(24)) bus1 ();

   pic_ram_reader #(.NPIX(16), .AW(18), .DW(24), .RD_LAT(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rst(rst), .start(start0), .bus(bus0), .busy(busy0), .frame_done(frame_done0)
   );

   pic_ram_reader #(.NPIX(16), .AW(18), .DW(24), .RD_LAT(3), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst(rst), .start(start1), .bus(bus1), .busy(busy1), .frame_done(frame_done1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [23:0] f(input int a);
      logic [15:0] x;
      x = a[15:0];
      return {x[7:0], ~x[7:0], x[15:8]};
   endfunction

   // RAM models: one-cycle and three-cycle read latency
   always @(posedge clk) bus0.RAM_PIC_Q <= f(int'(bus0.RAM_PIC_A));

   always @(posedge clk) begin
      p1 <= f(int'(bus1.RAM_PIC_A));
      p2 <= p1;
      bus1.RAM_PIC_Q <= p2;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_frame0();
      for (int i = 0; i < 16; i++) exp0.push_back({(i == 15), f(i)});
   endtask

   task automatic wait_done0(input string name, input int bound, input bit rnd);
      logic got;
      got = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(posedge clk); #1;
         if (frame_done0) begin
            got = 1'b1;
            break;
         end
         if (rnd) bus0.pix_ready = ($urandom_range(0, 99) < 30);
      end
      check(name, got, 1);
      bus0.pix_ready = 1'b1;
      @(posedge clk); #1;
      check({name, "_pulse"}, frame_done0, 0);
   endtask

   // Scoreboard monitor for the RD_LAT=1 reader
   always @(negedge clk) begin
      logic [24:0] e;
      if (rst) begin
         exp0.delete();
         issued0 = 0;
         acc0 = 0;
         stall0 = 1'b0;
      end else begin
         if (bus0.RAM_PIC_WE) we_seen0++;
         if (bus0.RAM_PIC_OE) begin
            issued0++;
            addr_log.push_back(bus0.RAM_PIC_A);
         end
         if (stall0) begin
            check("stall_valid", bus0.pix_valid, 1);
            check("stall_data", bus0.pix_data, hold_data);
            check("stall_last", bus0.pix_last, hold_last);
         end
         if (bus0.pix_valid && bus0.pix_ready) begin
            if (exp0.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", bus0.pix_data);
            end else begin
               e = exp0.pop_front();
               check("beat_data", bus0.pix_data, e[23:0]);
               check("beat_last", bus0.pix_last, e[24]);
            end
            acc0++;
            beats0++;
            last_hs_cycle = cycle;
            last_hs_last = bus0.pix_last;
         end
         if (frame_done0) begin
            check("frame_done_timing", cycle - last_hs_cycle, 1);
            check("frame_done_after_last", last_hs_last, 1);
         end
         if (issued0 - acc0 > max_out) max_out = issued0 - acc0;
         stall0 = bus0.pix_valid && !bus0.pix_ready;
         hold_data = bus0.pix_data;
         hold_last = bus0.pix_last;
      end
   end

   // Scoreboard monitor for the RD_LAT=3 reader
   always @(negedge clk) begin
      logic [24:0] e;
      if (!rst) begin
         if (bus1.RAM_PIC_WE) we_seen1++;
         if (bus1.pix_valid && bus1.pix_ready) begin
            if (exp1.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat_lat3: got data 0x%0h, expected no beat", bus1.pix_data);
            end else begin
               e = exp1.pop_front();
               check("lat3_data", bus1.pix_data, e[23:0]);
               check("lat3_last", bus1.pix_last, e[24]);
            end
            beats1++;
         end
      end
   end

   initial begin
      int lat, base_i, base_a, base_b, busy_cnt;
      logic got;
      rst = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      bus0.pix_ready = 1'b1;
      bus1.pix_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy0, 0);
      check("rst_valid", bus0.pix_valid, 0);
      check("rst_oe", bus0.RAM_PIC_OE, 0);
      check("rst_we", bus0.RAM_PIC_WE, 0);
      check("rst_addr", bus0.RAM_PIC_A, 0);
      check("rst_data", bus0.pix_data, 0);
      check("rst_last", bus0.pix_last, 0);
      check("rst_frame_done", frame_done0, 0);
      rst = 1'b0;

      // 1: full-rate frame, first-valid latency
      push_frame0();
      start0 = 1'b1;
      @(posedge clk);
      lat = 99;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (bus0.pix_valid) begin
            lat = k;
            break;
         end
      end
      check("first_valid_latency", lat, 3);
      wait_done0("t1_done", 100, 0);
      check("t1_queue_empty", exp0.size(), 0);

      // 4a: start held high must not retrigger
      busy_cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (busy0 || bus0.RAM_PIC_OE) busy_cnt++;
      end
      check("t4_no_retrigger", busy_cnt, 0);

      // 4b: drop start one cycle, second frame identical
      start0 = 1'b0;
      @(posedge clk); #1;
      push_frame0();
      start0 = 1'b1;
      wait_done0("t4_done", 100, 0);
      check("t4_queue_empty", exp0.size(), 0);

      // 2: random back-pressure
      start0 = 1'b0;
      @(posedge clk); #1;
      push_frame0();
      start0 = 1'b1;
      wait_done0("t2_done", 600, 1);
      check("t2_queue_empty", exp0.size(), 0);

      // 3: no ready, credit limit
      start0 = 1'b0;
      @(posedge clk); #1;
      base_i = issued0;
      base_a = addr_log.size();
      bus0.pix_ready = 1'b0;
      push_frame0();
      start0 = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("t3_reads_issued", issued0 - base_i, 4);
      for (int i = 0; i < 4; i++)
         if (addr_log.size() > base_a + i) check("t3_read_addr", addr_log[base_a + i], i);
      bus0.pix_ready = 1'b1;
      wait_done0("t3_done", 100, 0);
      check("t3_queue_empty", exp0.size(), 0);
      check("max_outstanding_le4", (max_out <= 4), 1);

      // 5: reset mid-frame, then clean restart
      start0 = 1'b0;
      @(posedge clk); #1;
      base_b = beats0;
      push_frame0();
      start0 = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (beats0 - base_b >= 7) begin
            got = 1'b1;
            break;
         end
      end
      check("t5_reached_beat7", got, 1);
      rst = 1'b1;
      start0 = 1'b0;
      @(posedge clk); #1;
      check("t5_busy", busy0, 0);
      check("t5_valid", bus0.pix_valid, 0);
      check("t5_oe", bus0.RAM_PIC_OE, 0);
      check("t5_addr", bus0.RAM_PIC_A, 0);
      check("t5_frame_done", frame_done0, 0);
      rst = 1'b0;
      push_frame0();
      start0 = 1'b1;
      wait_done0("t5_done", 100, 0);
      check("t5_queue_empty", exp0.size(), 0);

      // 6: RD_LAT=3 reader, full frame in order
      for (int i = 0; i < 16; i++) exp1.push_back({(i == 15), f(i)});
      start1 = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (frame_done1) begin
            got = 1'b1;
            break;
         end
      end
      check("t6_done", got, 1);
      check("t6_queue_empty", exp1.size(), 0);
      check("t6_beats", beats1, 16);
      check("we_never_high_lat1", we_seen0, 0);
      check("we_never_high_lat3", we_seen1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
